// File: rtl/rr_mux_arbiter_pkg.sv
// Shared types and constants for the two-requester round-robin mux arbiter.
// Holds the FSM state encoding, burst counter width and grant decode helper.
package rr_mux_arbiter_pkg;

  localparam int CNT_W = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT0 = 2'd1,
    GRANT1 = 2'd2
  } state_e;

  // One-hot grant vector presented while sitting in a given state.
  function automatic logic [1:0] gnt_of(input state_e st);
    logic [1:0] g;
    case (st)
      GRANT0:  g = 2'b01;
      GRANT1:  g = 2'b10;
      default: g = 2'b00;
    endcase
    return g;
  endfunction

  function automatic state_e grant_state(input logic idx);
    return idx ? GRANT1 : GRANT0;
  endfunction

endpackage

// File: rtl/rr_mux_arbiter_mux.sv
// DATA_W-wide 2:1 data mux used as the arbiter's data path.
module mux2to1_bus #(
  parameter int DATA_W = 8
) (
  input  logic              sel,
  input  logic [DATA_W-1:0] d0,
  input  logic [DATA_W-1:0] d1,
  output logic [DATA_W-1:0] y
);

  assign y = sel ? d1 : d0;

endmodule

// File: rtl/rr_mux_arbiter.sv
// Two-requester round-robin arbiter with registered grant/select and a data mux.
// Optional burst limiting is built when RR_MUX_ARBITER_BURST_LIMIT_EN is defined.
module rr_mux_arbiter
  import rr_mux_arbiter_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int MAX_BURST = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        req,
  input  logic              done,
  input  logic [DATA_W-1:0] data0,
  input  logic [DATA_W-1:0] data1,
  output logic [1:0]        gnt,
  output logic              sel,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  output logic              busy
);

  state_e     state_r;
  state_e     state_nxt_s;
  logic       ptr_r;
  logic       ptr_nxt_s;
  logic [1:0] gnt_r;
  logic       sel_r;
  logic       busy_r;
  logic       g_idx_s;
  logic       own_req_s;
  logic       oth_req_s;
  logic       limit_s;
  logic       release_s;
  logic       cnt_clr_s;
  logic       out_valid_s;

  assign out_valid_s = |(gnt_r & req);
  assign gnt         = gnt_r;
  assign sel         = sel_r;
  assign busy        = busy_r;
  assign out_valid   = out_valid_s;

`ifdef RR_MUX_ARBITER_BURST_LIMIT_EN
  localparam logic [CNT_W-1:0] BURST_LAST = CNT_W'(MAX_BURST - 1);

  logic [CNT_W-1:0] cnt_r;

  assign limit_s = out_valid_s & (cnt_r == BURST_LAST);

  // Burst counter: restarts on every (re)grant, counts valid granted cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (cnt_clr_s) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (out_valid_s) begin
      cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      cnt_r <= cnt_r;
    end
  end
`else
  assign limit_s = 1'b0;
`endif

  // Next-state, pointer update and counter-restart decisions.
  always_comb begin
    state_nxt_s = state_r;
    ptr_nxt_s   = ptr_r;
    cnt_clr_s   = 1'b0;
    g_idx_s     = (state_r == GRANT1);
    own_req_s   = req[g_idx_s];
    oth_req_s   = req[~g_idx_s];
    release_s   = done | ~own_req_s | limit_s;
    case (state_r)
      IDLE: begin
        cnt_clr_s = 1'b1;
        case (req)
          2'b01:   state_nxt_s = GRANT0;
          2'b10:   state_nxt_s = GRANT1;
          2'b11:   state_nxt_s = grant_state(ptr_r);
          default: state_nxt_s = IDLE;
        endcase
      end
      GRANT0, GRANT1: begin
        if (release_s) begin
          ptr_nxt_s = ~g_idx_s;
          cnt_clr_s = 1'b1;
          if (oth_req_s) begin
            state_nxt_s = grant_state(~g_idx_s);
          end else if (own_req_s && limit_s && !done) begin
            // Burst limit alone with nobody waiting: re-grant the same requester.
            state_nxt_s = state_r;
          end else begin
            state_nxt_s = IDLE;
          end
        end else begin
          state_nxt_s = state_r;
        end
      end
      default: begin
        state_nxt_s = IDLE;
        cnt_clr_s   = 1'b1;
      end
    endcase
  end

  // Control registers; outputs are decoded from the next state so they align with it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      ptr_r   <= 1'b0;
      gnt_r   <= 2'b00;
      sel_r   <= 1'b0;
      busy_r  <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      ptr_r   <= ptr_nxt_s;
      gnt_r   <= gnt_of(state_nxt_s);
      busy_r  <= (state_nxt_s != IDLE);
      case (state_nxt_s)
        GRANT0:  sel_r <= 1'b0;
        GRANT1:  sel_r <= 1'b1;
        default: sel_r <= sel_r;
      endcase
    end
  end

  mux2to1_bus #(
    .DATA_W (DATA_W)
  ) u_mux (
    .sel (sel_r),
    .d0  (data0),
    .d1  (data1),
    .y   (out_data)
  );

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Scoreboard bench for rr_mux_arbiter: driver pushes model predictions, monitor compares.
module tb_rr_mux_arbiter;

  localparam int DW = 8;
  localparam int MB = 4;
`ifdef RR_MUX_ARBITER_BURST_LIMIT_EN
  localparam bit BURST_EN = 1'b1;
`else
  localparam bit BURST_EN = 1'b0;
`endif

  typedef struct packed {
    logic [1:0]    gnt;
    logic          sel;
    logic          busy;
    logic          ov;
    logic [DW-1:0] od;
  } exp_t;

  logic          clk;
  logic          rst_n;
  logic [1:0]    req;
  logic          done;
  logic [DW-1:0] data0;
  logic [DW-1:0] data1;
  logic [1:0]    gnt;
  logic          sel;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          busy;

  int   tests;
  int   fails;
  exp_t q[$];

  // Reference model: who holds the grant (-1 none), who is favoured, burst length.
  int   holder;
  int   ptr_m;
  int   cnt_m;
  logic sel_m;

  rr_mux_arbiter #(.DATA_W(DW), .MAX_BURST(MB)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .done      (done),
    .data0     (data0),
    .data1     (data1),
    .gnt       (gnt),
    .sel       (sel),
    .out_data  (out_data),
    .out_valid (out_valid),
    .busy      (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    holder = -1;
    ptr_m  = 0;
    cnt_m  = 0;
    sel_m  = 1'b0;
  endtask

  task automatic model_step(input logic [1:0] r, input logic d);
    int  g;
    bit  own, oth, lim;
    if (holder < 0) begin
      if (r == 2'b01)      holder = 0;
      else if (r == 2'b10) holder = 1;
      else if (r == 2'b11) holder = ptr_m;
      cnt_m = 0;
    end else begin
      g   = holder;
      own = r[g];
      oth = r[1-g];
      lim = BURST_EN && own && (cnt_m == MB - 1);
      if (d || !own || lim) begin
        ptr_m = 1 - g;
        cnt_m = 0;
        if (oth)                 holder = 1 - g;
        else if (own && lim && !d) holder = g;
        else                     holder = -1;
      end else begin
        cnt_m++;
      end
    end
    if (holder >= 0) sel_m = (holder == 1);
  endtask

  function automatic exp_t predict(input logic [1:0] r, input logic [DW-1:0] d0, input logic [DW-1:0] d1);
    exp_t e;
    e.gnt  = (holder < 0) ? 2'b00 : ((holder == 0) ? 2'b01 : 2'b10);
    e.sel  = sel_m;
    e.busy = (holder >= 0);
    e.ov   = (holder >= 0) && r[holder];
    e.od   = sel_m ? d1 : d0;
    return e;
  endfunction

  // One clock of stimulus: drive at the falling edge, queue the post-edge expectation.
  task automatic cycle(input logic [1:0] r, input logic d, input logic rn);
    @(negedge clk);
    req   = r;
    done  = d;
    rst_n = rn;
    data0 = DW'($urandom);
    data1 = DW'($urandom);
    if (!rn) model_reset();
    else     model_step(r, d);
    q.push_back(predict(r, data0, data1));
  endtask

  // Monitor: after every rising edge compare DUT outputs with the oldest prediction.
  initial begin
    exp_t e;
    exp_t a;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        a = '{gnt: gnt, sel: sel, busy: busy, ov: out_valid, od: out_data};
        tests++;
        if (a !== e) begin
          fails++;
          $display("FAIL scoreboard: got gnt=%b sel=%b busy=%b ov=%b od=%h expected gnt=%b sel=%b busy=%b ov=%b od=%h at %0t",
                   a.gnt, a.sel, a.busy, a.ov, a.od, e.gnt, e.sel, e.busy, e.ov, e.od, $time);
        end
      end
    end
  end

  initial begin
    tests = 0;
    fails = 0;
    model_reset();
    rst_n = 1'b0;
    req   = 2'b11;
    done  = 1'b0;
    data0 = 8'hA5;
    data1 = 8'h5A;

    // Held in reset with both requesting: nothing granted, data0 routed.
    #17;
    chk("reset_gnt", 32'(gnt), 32'h0);
    chk("reset_sel", 32'(sel), 32'h0);
    chk("reset_busy", 32'(busy), 32'h0);
    chk("reset_valid", 32'(out_valid), 32'h0);
    chk("reset_data", 32'(out_data), 32'hA5);
    cycle(2'b11, 1'b0, 1'b0);

    // Single requester 1 then done.
    cycle(2'b10, 1'b0, 1'b1);
    cycle(2'b10, 1'b0, 1'b1);
    cycle(2'b10, 1'b1, 1'b1);
    cycle(2'b00, 1'b0, 1'b1);
    cycle(2'b00, 1'b1, 1'b1);

    // Contention from reset: 0 first, then alternate on done.
    cycle(2'b11, 1'b0, 1'b0);
    cycle(2'b11, 1'b0, 1'b1);
    cycle(2'b11, 1'b1, 1'b1);
    cycle(2'b11, 1'b1, 1'b1);
    cycle(2'b11, 1'b0, 1'b1);

    // Long holds: both requesting without done, then requester 0 alone.
    for (int i = 0; i < 20; i++) cycle(2'b11, 1'b0, 1'b1);
    for (int i = 0; i < 14; i++) cycle(2'b01, 1'b0, 1'b1);
    for (int i = 0; i < 14; i++) cycle(2'b10, 1'b0, 1'b1);
    cycle(2'b11, 1'b0, 1'b1);
    cycle(2'b01, 1'b1, 1'b1);

    // Randomised traffic with occasional done pulses.
    for (int i = 0; i < 600; i++) begin
      cycle(2'($urandom_range(0, 3)), ($urandom_range(0, 3) == 0), 1'b1);
    end

    // Asynchronous reset while requester 1 holds the grant.
    cycle(2'b00, 1'b0, 1'b1);
    cycle(2'b00, 1'b0, 1'b1);
    cycle(2'b10, 1'b0, 1'b1);
    cycle(2'b10, 1'b0, 1'b1);
    @(negedge clk);
    req   = 2'b10;
    done  = 1'b0;
    data0 = 8'h3C;
    data1 = 8'hC3;
    chk("pre_reset_gnt", 32'(gnt), 32'h2);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_reset_gnt", 32'(gnt), 32'h0);
    chk("async_reset_data", 32'(out_data), 32'h3C);
    model_reset();
    q.push_back(predict(req, data0, data1));
    cycle(2'b11, 1'b0, 1'b0);
    cycle(2'b11, 1'b0, 1'b1);
    cycle(2'b11, 1'b0, 1'b1);

    @(posedge clk);
    #2;
    chk("queue_drained", 32'(q.size()), 32'h0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
